// File: rtl/bin_to_bcd_converter_if.sv
// Handshake and result bus for bin_to_bcd_converter.
// master drives the request side, slave (the converter) drives results.
interface bin_to_bcd_converter_if;
    logic [13:0] bin_input;
    logic        start;
    logic        busy;
    logic [3:0]  unidades_output;
    logic [3:0]  decenas_output;
    logic [3:0]  centenas_output;
    logic [3:0]  millares_output;
    logic        ready;
    logic        ovf;

    modport master (
        output bin_input, start,
        input  busy, unidades_output, decenas_output, centenas_output,
               millares_output, ready, ovf
    );

    modport slave (
        input  bin_input, start,
        output busy, unidades_output, decenas_output, centenas_output,
               millares_output, ready, ovf
    );
endinterface

// File: rtl/bin_to_bcd_converter.sv
// Iterative double-dabble 14-bit binary to 4-digit BCD converter (one bit per cycle).
// Optional macro BIN_TO_BCD_SATURATE_EN: values > 9999 saturate to 9999 with ovf=1.
//
// state  | meaning
// IDLE   | waiting for start; input captured on acceptance
// SHIFT  | 14 add-3/shift iterations, MSB first
// DONE   | result registered at the exit edge, ready pulses afterwards
module bin_to_bcd_converter (
    input  logic                   clk,
    input  logic                   rst,
    bin_to_bcd_converter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [13:0] bin_q, bin_d;
    logic [19:0] bcd_q, bcd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] digits_q, digits_d;
    logic        ovf_q, ovf_d;
    logic        ready_q, ready_d;
    logic [19:0] bcd_adj;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            digits_q <= '0;
            ovf_q    <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            ovf_q    <= ovf_d;
            ready_q  <= ready_d;
        end
    end

    // Add 3 to every nibble >= 5 so the following left shift carries correctly.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 5; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5)
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_d  = state_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        digits_d = digits_q;
        ovf_d    = ovf_q;
        ready_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    bin_d   = bus.bin_input;
                    bcd_d   = '0;
                    cnt_d   = 4'd13;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                {bcd_d, bin_d} = {bcd_adj[18:0], bin_q, 1'b0};
                if (cnt_q == 4'd0)
                    state_d = ST_DONE;
                else
                    cnt_d = cnt_q - 4'd1;
            end
            ST_DONE: begin
                ready_d = 1'b1;
                state_d = ST_IDLE;
`ifdef BIN_TO_BCD_SATURATE_EN
                if (bcd_q[19:16] != 4'd0) begin
                    digits_d = 16'h9999;
                    ovf_d    = 1'b1;
                end else begin
                    digits_d = bcd_q[15:0];
                    ovf_d    = 1'b0;
                end
`else
                digits_d = bcd_q[15:0];
                ovf_d    = 1'b0;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.busy            = (state_q != ST_IDLE);
    assign bus.ready           = ready_q;
    assign bus.ovf             = ovf_q;
    assign bus.millares_output = digits_q[15:12];
    assign bus.centenas_output = digits_q[11:8];
    assign bus.decenas_output  = digits_q[7:4];
    assign bus.unidades_output = digits_q[3:0];

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Directed self-checking bench for bin_to_bcd_converter.
module tb_bin_to_bcd_converter;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    bin_to_bcd_converter_if bus ();

    bin_to_bcd_converter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] digits();
        return {bus.millares_output, bus.centenas_output,
                bus.decenas_output, bus.unidades_output};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycles from the accepting edge until ready is seen; -1 if it never comes.
    task automatic wait_ready(output int cyc);
        cyc = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (bus.ready === 1'b1) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic launch(input logic [13:0] val);
        bus.bin_input = val;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.bin_input = 14'd0;
        repeat (3) tick();
        rst = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.ready !== 1'b0 || bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags busy=%b ready=%b ovf=%b expected 0/0/0",
                     bus.busy, bus.ready, bus.ovf);
        end
        checks++;
        if (digits() !== 16'h0000) begin
            errors++;
            $display("FAIL reset_digits got %h expected 0000", digits());
        end
    endtask

    task automatic test_basic();
        int c;
        launch(14'd7609);
        bus.bin_input = 14'd0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy got %b expected 1", bus.busy);
        end
        wait_ready(c);
        checks++;
        if (c != 15) begin
            errors++;
            $display("FAIL basic_latency got %0d expected 15", c);
        end
        checks++;
        if (digits() !== 16'h7609 || bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL basic_digits got %h ovf=%b expected 7609 ovf=0", digits(), bus.ovf);
        end
        tick();
        checks++;
        if (bus.ready !== 1'b0 || bus.busy !== 1'b0 || digits() !== 16'h7609) begin
            errors++;
            $display("FAIL basic_hold ready=%b busy=%b digits=%h expected 0/0/7609",
                     bus.ready, bus.busy, digits());
        end
    endtask

    task automatic test_back_to_back();
        int c;
        launch(14'd0);
        wait_ready(c);
        checks++;
        if (c != 15 || digits() !== 16'h0000 || bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first lat=%0d digits=%h ovf=%b expected 15/0000/0", c, digits(), bus.ovf);
        end
        launch(14'd9999);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept busy=%b expected 1", bus.busy);
        end
        wait_ready(c);
        checks++;
        if (c != 15 || digits() !== 16'h9999 || bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second lat=%0d digits=%h ovf=%b expected 15/9999/0", c, digits(), bus.ovf);
        end
    endtask

    task automatic test_start_ignored();
        int pulses = 0;
        int first  = -1;
        launch(14'd3193);
        repeat (4) tick();
        bus.bin_input = 14'd94;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 6; k <= 30; k++) begin
            bus.start = (k == 15);
            tick();
            if (bus.ready === 1'b1) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
        bus.start = 1'b0;
        checks++;
        if (pulses != 1 || first != 15) begin
            errors++;
            $display("FAIL ignore_pulses got %0d at %0d expected 1 at 15", pulses, first);
        end
        checks++;
        if (digits() !== 16'h3193 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_result digits=%h busy=%b expected 3193/0", digits(), bus.busy);
        end
    endtask

    task automatic test_reset_abort();
        int c;
        int pulses = 0;
        launch(14'd3193);
        repeat (6) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.ready !== 1'b0 || digits() !== 16'h0000 || bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL abort_state busy=%b ready=%b digits=%h ovf=%b expected 0/0/0000/0",
                     bus.busy, bus.ready, digits(), bus.ovf);
        end
        repeat (20) begin
            tick();
            if (bus.ready === 1'b1 || bus.busy === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL abort_quiet got %0d active cycles expected 0", pulses);
        end
        launch(14'd94);
        wait_ready(c);
        checks++;
        if (c != 15 || digits() !== 16'h0094) begin
            errors++;
            $display("FAIL abort_restart lat=%0d digits=%h expected 15/0094", c, digits());
        end
    endtask

    task automatic test_overflow();
        int c;
        launch(14'd12345);
        wait_ready(c);
        checks++;
`ifdef BIN_TO_BCD_SATURATE_EN
        if (c != 15 || digits() !== 16'h9999 || bus.ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sat lat=%0d digits=%h ovf=%b expected 15/9999/1", c, digits(), bus.ovf);
        end
`else
        if (c != 15 || digits() !== 16'h2345 || bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_wrap lat=%0d digits=%h ovf=%b expected 15/2345/0", c, digits(), bus.ovf);
        end
`endif
        launch(14'd16383);
        wait_ready(c);
        checks++;
`ifdef BIN_TO_BCD_SATURATE_EN
        if (digits() !== 16'h9999 || bus.ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_max digits=%h ovf=%b expected 9999/1", digits(), bus.ovf);
        end
`else
        if (digits() !== 16'h6383 || bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_max digits=%h ovf=%b expected 6383/0", digits(), bus.ovf);
        end
`endif
    endtask

    task automatic test_rst_start();
        int active = 0;
        bus.bin_input = 14'd5;
        bus.start = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.ready !== 1'b0) begin
            errors++;
            $display("FAIL rststart_idle busy=%b ready=%b expected 0/0", bus.busy, bus.ready);
        end
        repeat (20) begin
            tick();
            if (bus.ready === 1'b1 || bus.busy === 1'b1) active++;
        end
        checks++;
        if (active != 0 || digits() !== 16'h0000) begin
            errors++;
            $display("FAIL rststart_quiet active=%0d digits=%h expected 0/0000", active, digits());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_start_ignored();
        test_reset_abort();
        test_overflow();
        test_rst_start();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
